// File: rtl/audio_ch_sched.sv
// Double-buffered per-channel sample collector feeding the frame serializer in channel order.
// Issues one sample per cycle over valid/ready from the cycle after a frame tick; stalls hold data.
module audio_ch_sched #(
  parameter int NCH = 8,
  parameter int DW  = 32
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic [DW-1:0] ich_data,
  input  logic [3:0]    ich_num,
  input  logic          ich_data_valid,
  input  logic          iframe_tick,
  output logic [DW-1:0] osmp_data,
  output logic [3:0]    osmp_num,
  output logic          osmp_valid,
  input  logic          ismp_ready,
  output logic          ounderrun,
  output logic          ooverrun,
  output logic          orange_err,
  output logic          oframe_late
);

  localparam logic [4:0] NCH5 = 5'(NCH);
  localparam logic [3:0] LAST = 4'(NCH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state, state_nx;
  logic [3:0]     idx, idx_nx;
  logic           wsel, wsel_nx;
  logic [NCH-1:0] mask0, mask1;
  logic [DW-1:0]  bank0 [NCH];
  logic [DW-1:0]  bank1 [NCH];

  logic           in_range, swap, xfer, rd_bit;
  logic [NCH-1:0] dec, wr_vec, wmask, rmask;
  logic [DW-1:0]  rd_word;

  always_comb begin
    in_range = {1'b0, ich_num} < NCH5;
    swap     = (state == IDLE) && iframe_tick;
    wsel_nx  = wsel ^ swap;
    wmask    = wsel ? mask1 : mask0;
    rmask    = wsel ? mask0 : mask1;
    for (int c = 0; c < NCH; c++) dec[c] = (ich_num == 4'(c));
    wr_vec   = (ich_data_valid && in_range) ? dec : '0;
  end

  // Read bank is the one not selected for writing.
  always_comb begin
    rd_word = '0;
    rd_bit  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (idx == 4'(c)) begin
        rd_word = wsel ? bank0[c] : bank1[c];
        rd_bit  = rmask[c];
      end
    end
  end

  assign osmp_valid = (state == SEND);
  assign osmp_num   = osmp_valid ? idx : 4'd0;
  assign osmp_data  = (osmp_valid && rd_bit) ? rd_word : '0;
  assign xfer       = osmp_valid && ismp_ready;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: if (iframe_tick) begin
        state_nx = SEND;
        idx_nx   = 4'd0;
      end
      SEND: if (xfer) begin
        if (idx == LAST) begin
          state_nx = IDLE;
          idx_nx   = 4'd0;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // On a swap the new write bank's mask restarts from this cycle's write alone.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      wsel  <= 1'b0;
      mask0 <= '0;
      mask1 <= '0;
    end else begin
      wsel <= wsel_nx;
      if (swap) begin
        if (wsel) mask0 <= wr_vec;
        else      mask1 <= wr_vec;
      end else begin
        if (wsel) mask1 <= mask1 | wr_vec;
        else      mask0 <= mask0 | wr_vec;
      end
    end
  end

  always_ff @(posedge iclk) begin
    for (int c = 0; c < NCH; c++) begin
      if (wr_vec[c]) begin
        if (wsel_nx) bank1[c] <= ich_data;
        else         bank0[c] <= ich_data;
      end
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ounderrun   <= 1'b0;
      ooverrun    <= 1'b0;
      orange_err  <= 1'b0;
      oframe_late <= 1'b0;
    end else begin
      ounderrun   <= swap && !(&wmask);
      ooverrun    <= !swap && (|(wr_vec & wmask));
      orange_err  <= ich_data_valid && !in_range;
      oframe_late <= iframe_tick && (state == SEND);
    end
  end

endmodule

// File: tb/tb_audio_ch_sched.sv
// Directed bench for audio_ch_sched (NCH=8, DW=32) with hand-computed expectations.
module tb_audio_ch_sched;

  logic        iclk = 1'b0;
  logic        irst;
  logic [31:0] ich_data;
  logic [3:0]  ich_num;
  logic        ich_data_valid;
  logic        iframe_tick;
  logic [31:0] osmp_data;
  logic [3:0]  osmp_num;
  logic        osmp_valid;
  logic        ismp_ready;
  logic        ounderrun, ooverrun, orange_err, oframe_late;

  int n_chk  = 0;
  int n_fail = 0;
  int tid    = 0;

  audio_ch_sched #(.NCH(8), .DW(32)) dut (
    .iclk(iclk), .irst(irst),
    .ich_data(ich_data), .ich_num(ich_num), .ich_data_valid(ich_data_valid),
    .iframe_tick(iframe_tick),
    .osmp_data(osmp_data), .osmp_num(osmp_num), .osmp_valid(osmp_valid),
    .ismp_ready(ismp_ready),
    .ounderrun(ounderrun), .ooverrun(ooverrun), .orange_err(orange_err),
    .oframe_late(oframe_late)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL test%0d %s: got %h expected %h", tid, tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic write(input logic [3:0] n, input logic [31:0] d);
    ich_data_valid = 1'b1;
    ich_num        = n;
    ich_data       = d;
    step();
    ich_data_valid = 1'b0;
  endtask

  task automatic tick();
    iframe_tick = 1'b1;
    step();
    iframe_tick = 1'b0;
  endtask

  task automatic drain(input logic [31:0] base, input logic [7:0] present);
    ismp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("valid", 32'(osmp_valid), 32'd1);
      check("num", 32'(osmp_num), 32'(i));
      check("data", osmp_data, present[i] ? base + 32'(i) : 32'd0);
      step();
    end
    check("valid_end", 32'(osmp_valid), 32'd0);
  endtask

  initial begin
    irst = 1'b1; ich_data = '0; ich_num = '0; ich_data_valid = 1'b0;
    iframe_tick = 1'b0; ismp_ready = 1'b1;
    step(); step();
    check("rst_valid", 32'(osmp_valid), 32'd0);
    check("rst_data", osmp_data, 32'd0);
    check("rst_flags", {28'd0, ounderrun, ooverrun, orange_err, oframe_late}, 32'd0);
    irst = 1'b0;
    step();

    // full frame, no flags
    tid = 1;
    for (int n = 0; n < 8; n++) write(4'(n), 32'h1000_0000 + 32'(n));
    check("no_ovr", 32'(ooverrun), 32'd0);
    tick();
    check("valid_t1", 32'(osmp_valid), 32'd1);
    check("no_undr", 32'(ounderrun), 32'd0);
    drain(32'h1000_0000, 8'hFF);
    check("no_late", 32'(oframe_late), 32'd0);

    // partial frame -> underrun, zeros for 6,7
    tid = 2;
    for (int n = 0; n < 6; n++) write(4'(n), 32'h2000_0000 + 32'(n));
    tick();
    check("undr", 32'(ounderrun), 32'd1);
    drain(32'h2000_0000, 8'h3F);
    check("undr_clr", 32'(ounderrun), 32'd0);

    // overwrite then range error
    tid = 3;
    write(4'd3, 32'h0000_000A);
    check("ovr_first", 32'(ooverrun), 32'd0);
    write(4'd3, 32'h0000_000B);
    check("ovr", 32'(ooverrun), 32'd1);
    check("rng_none", 32'(orange_err), 32'd0);
    write(4'd9, 32'hDEAD_BEEF);
    check("rng", 32'(orange_err), 32'd1);
    check("ovr_clr", 32'(ooverrun), 32'd0);
    step();
    check("rng_clr", 32'(orange_err), 32'd0);
    tick();
    check("undr3", 32'(ounderrun), 32'd1);
    drain(32'h0000_0008, 8'h08);

    // stalled handshake: ready pattern 1,0,0,1
    tid = 4;
    for (int n = 0; n < 8; n++) write(4'(n), 32'h4000_0000 + 32'(n));
    ismp_ready = 1'b0;
    tick();
    begin
      int e = 0;
      for (int cyc = 0; cyc < 40 && e < 8; cyc++) begin
        ismp_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        check("s_valid", 32'(osmp_valid), 32'd1);
        check("s_num", 32'(osmp_num), 32'(e));
        check("s_data", osmp_data, 32'h4000_0000 + 32'(e));
        step();
        if (ismp_ready) e++;
      end
      check("s_beats", 32'(e), 32'd8);
    end
    check("s_idle", 32'(osmp_valid), 32'd0);
    ismp_ready = 1'b1;

    // late tick at idx 4
    tid = 5;
    for (int n = 0; n < 8; n++) write(4'(n), 32'h5000_0000 + 32'(n));
    tick();
    for (int i = 0; i < 4; i++) begin
      check("l_num", 32'(osmp_num), 32'(i));
      step();
    end
    check("l_num4", 32'(osmp_num), 32'd4);
    check("l_data4", osmp_data, 32'h5000_0004);
    iframe_tick = 1'b1;
    step();
    iframe_tick = 1'b0;
    check("late", 32'(oframe_late), 32'd1);
    for (int i = 5; i < 8; i++) begin
      check("l_num", 32'(osmp_num), 32'(i));
      check("l_data", osmp_data, 32'h5000_0000 + 32'(i));
      step();
    end
    check("l_idle", 32'(osmp_valid), 32'd0);
    check("late_clr", 32'(oframe_late), 32'd0);

    // normal swap after late tick, then reset at idx 3
    tid = 6;
    for (int n = 0; n < 8; n++) write(4'(n), 32'h6000_0000 + 32'(n));
    tick();
    check("r_undr", 32'(ounderrun), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("r_data", osmp_data, 32'h6000_0000 + 32'(i));
      step();
    end
    check("r_num3", 32'(osmp_num), 32'd3);
    irst = 1'b1;
    #1;
    check("r_valid", 32'(osmp_valid), 32'd0);
    check("r_num", 32'(osmp_num), 32'd0);
    step();
    irst = 1'b0;
    step();
    tick();
    check("r_undr2", 32'(ounderrun), 32'd1);
    drain(32'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
